screen_scanner: RTL and testbench
=================================

// Module: screen_scanner
// PURPOSE
//   Raster read-out engine for the Hack 512x256 monochrome screen buffer.
//   Sits downstream of the 8K-word screen RAM: it drives the RAM read address and
//   serialises each 16-bit word into a one-bit-per-cycle pixel stream with
//   blanking, sync and frame markers for a display back-end.
//   Read-only: it never writes the RAM.
// PARAMETERS
//   H_ACTIVE  512  visible pixels per line; must be a multiple of 16
//   V_ACTIVE  256  visible lines per frame; (H_ACTIVE/16)*V_ACTIVE <= 8192
//   H_BLANK   16   blank cycles after each line's active pixels (>=1)
//   V_BLANK   4    blank lines after the last active line (>=1)
// PORTS
//   clock        in   1   single clock; all state updates on posedge
//   reset        in   1   synchronous, active-high
//   enable       in   1   1 = scan advances this cycle; 0 = all state holds
//   address      out  13  screen RAM read address (combinational from counters)
//   data         in   16  screen RAM read data; combinational read of address
//   pixel        out  1   current pixel, registered
//   pixel_valid  out  1   pixel is inside the active region, registered
//   hsync        out  1   high during horizontal blank cycles, registered
//   vsync        out  1   high for every cycle of a vertical-blank line, registered
//   frame_start  out  1   one-cycle pulse with the first pixel (0,0) of each frame
// BEHAVIOUR
// - Counters:
//   - x: 0..H_ACTIVE+H_BLANK-1.
//   - y: 0..V_ACTIVE+V_BLANK-1.
//   - With enable=1, x increments each cycle. At x max, x wraps to 0 and y
//     increments. At (x max, y max), both wrap to 0 and a new frame begins.
// - Active region: x<H_ACTIVE and y<V_ACTIVE.
// - Address:
//   - address = y*(H_ACTIVE/16) + x/16 while active (defaults: {y[7:0],x[8:4]}).
//   - Outside the active region, address holds its last active value.
//   - Use a row-base register; no multiplier.
// - Pixel mapping (Hack): pixel (r,c) = bit c%16 of word r*32 + c/16, LSB leftmost.
// - Word fetch and shift, when enable=1 and the cycle is active:
//   - If x%16==0: sample data, shreg <= data>>1, pixel <= data[0].
//   - Otherwise: pixel <= shreg[0], shreg <= shreg>>1.
//   - A RAM write to a word after its fetch cycle does not alter that word's
//     pixels in the current frame.
// - Latency:
//   - pixel, pixel_valid, hsync, vsync and frame_start reflect the counter state
//     of the previous enabled cycle (1-cycle latency).
//   - Outside the active region: pixel=0, pixel_valid=0.
// - hsync = (x>=H_ACTIVE); vsync = (y>=V_ACTIVE); both registered.
// - frame_start = 1 only in the cycle after the enabled cycle with x=0, y=0.
// - enable=0: counters, shreg and all registered outputs hold their values,
//   except frame_start, which is forced 0. No pixel is lost or duplicated across
//   a stall.
// - Reset:
//   - On reset=1 at posedge: x=y=0, shreg=0, pixel=0, pixel_valid=0, hsync=0,
//     vsync=0, frame_start=0.
//   - Reset overrides enable.
//   - Reset mid-frame restarts the scan at address 0 on the next cycle.
// CONFIGURATION
// - SCREEN_SCANNER_FRAME_COUNT_EN defined:
//   - Adds output port frame_count (out, 16): registered, reset to 0.
//   - Increments by 1 on the enabled cycle where x and y both wrap to 0.
//   - Wraps from 16'hFFFF to 0.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING
// 1. Reset, enable=1, RAM[0]=16'h0001:
//    -> address=0 in the first cycle; pixel stream 1,0,0,...,0 (16 px) with
//       pixel_valid=1 and frame_start=1 on the first pixel only.
// 2. RAM[31]=16'h8000:
//    -> address=31 while x=496..511; pixel=1 exactly at x=511 of row 0,
//       0 at x=496..510.
// 3. Run one line:
//    -> hsync=1, pixel_valid=0, pixel=0 for exactly 16 cycles (x=512..527);
//       next line's first fetch address=32.
// 4. Run full frame:
//    -> last active fetch address=8191; vsync=1 for 4*528 cycles;
//       frame_start period=137280 cycles.
// 5. RAM[0]=16'hAAAA; enable=0 for 5 cycles after the 3rd pixel:
//    -> outputs frozen, frame_start=0; resumes with pattern 0,1,0,1,...
//       intact, no skipped or repeated bit.
// 6. Assert reset at line 100, x=200:
//    -> next cycle all outputs 0; scan restarts at address 0.
//    With SCREEN_SCANNER_FRAME_COUNT_EN: frame_count reads 0 after reset,
//    and 0->1->2 after two full frames.

Source files
------------

// File: rtl/screen_scanner.sv
// screen_scanner: raster read-out of the Hack screen RAM as a 1-bit pixel stream with sync markers.
// Define SCREEN_SCANNER_FRAME_COUNT_EN to add the 16-bit frame_count_o output.
module screen_scanner #(
   parameter int H_ACTIVE = 512,
   parameter int V_ACTIVE = 256,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_i,
   output logic [12:0] address_o,
   input  logic [15:0] data_i,
   output logic        pixel_o,
   output logic        pixel_valid_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        frame_start_o
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
   ,
   output logic [15:0] frame_count_o
`endif
);
   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int XW = $clog2(H_TOTAL);
   localparam int YW = $clog2(V_TOTAL);
   localparam logic [12:0] ROW_WORDS = 13'(H_ACTIVE / 16);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [12:0]   row_base_q, row_base_d;
   logic [12:0]   last_addr_q;
   logic [12:0]   active_addr;
   logic [15:0]   shreg_q;
   logic          pixel_q, pixel_valid_q, hsync_q, vsync_q, frame_start_q;
   logic          x_last, y_last, active;
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
   logic [15:0]   frame_count_q;
`endif

   // The row base steps by one row of words per line, so no multiplier is needed.
   always_comb begin
      x_last      = (x_q == XW'(H_TOTAL - 1));
      y_last      = (y_q == YW'(V_TOTAL - 1));
      active      = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
      active_addr = row_base_q + 13'(x_q >> 4);
      x_d         = x_q + 1'b1;
      y_d         = y_q;
      row_base_d  = row_base_q;
      if (x_last) begin
         x_d = '0;
         if (y_last) begin
            y_d        = '0;
            row_base_d = '0;
         end else begin
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + ROW_WORDS;
         end
      end
   end

   // Blanking keeps presenting the last fetched address to the RAM.
   assign address_o = active ? active_addr : last_addr_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         x_q           <= '0;
         y_q           <= '0;
         row_base_q    <= '0;
         last_addr_q   <= '0;
         shreg_q       <= '0;
         pixel_q       <= 1'b0;
         pixel_valid_q <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
         frame_count_q <= '0;
`endif
      end else if (enable_i) begin
         x_q           <= x_d;
         y_q           <= y_d;
         row_base_q    <= row_base_d;
         hsync_q       <= (x_q >= XW'(H_ACTIVE));
         vsync_q       <= (y_q >= YW'(V_ACTIVE));
         frame_start_q <= (x_q == '0) && (y_q == '0);
         if (active) begin
            last_addr_q   <= active_addr;
            pixel_valid_q <= 1'b1;
            if (x_q[3:0] == 4'd0) begin
               shreg_q <= data_i >> 1;
               pixel_q <= data_i[0];
            end else begin
               shreg_q <= shreg_q >> 1;
               pixel_q <= shreg_q[0];
            end
         end else begin
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
         end
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
         if (x_last && y_last) frame_count_q <= frame_count_q + 16'd1;
`endif
      end else begin
         frame_start_q <= 1'b0;
      end
   end

   assign pixel_o       = pixel_q;
   assign pixel_valid_o = pixel_valid_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign frame_start_o = frame_start_q;
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
   assign frame_count_o = frame_count_q;
`endif
endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner on a reduced 64x4 screen (16 h-blank, 4 v-blank, 640-cycle frame).
// Frame counter checks are built when SCREEN_SCANNER_FRAME_COUNT_EN is defined.
module tb_screen_scanner;
   localparam int HA = 64;
   localparam int VA = 4;
   localparam int HB = 16;
   localparam int VB = 4;
   localparam int HT = HA + HB;
   localparam int VT = VA + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [12:0] address;
   logic [15:0] data;
   logic        pixel, pixel_valid, hsync, vsync, frame_start;
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif
   logic [15:0] ram [0:8191];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Screen RAM model: combinational read.
   assign data = ram[address];

   screen_scanner #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
      .clock_i       (clk),
      .reset_i       (reset),
      .enable_i      (enable),
      .address_o     (address),
      .data_i        (data),
      .pixel_o       (pixel),
      .pixel_valid_o (pixel_valid),
      .hsync_o       (hsync),
      .vsync_o       (vsync),
      .frame_start_o (frame_start)
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
      ,
      .frame_count_o (frame_count)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ram();
      for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b1;
      step();
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      clear_ram();
      do_reset();
      total++;
      if ({pixel, pixel_valid, hsync, vsync, frame_start} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=00000", {pixel, pixel_valid, hsync, vsync, frame_start});
      end
      total++;
      if (address !== 13'd0) begin
         bad++;
         $display("FAIL reset_address got=%0d want=0", address);
      end
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
      total++;
      if (frame_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_frame_count got=%0d want=0", frame_count);
      end
`endif
   endtask

   task automatic test_first_word();
      clear_ram();
      ram[0] = 16'h0001;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         total++;
         if (address !== 13'd0) begin
            bad++;
            $display("FAIL first_word_addr x=%0d got=%0d want=0", i, address);
         end
         step();
         total++;
         if ({pixel, pixel_valid, frame_start} !== {(i == 0), 1'b1, (i == 0)}) begin
            bad++;
            $display("FAIL first_word_px x=%0d got=%b want=%b", i, {pixel, pixel_valid, frame_start},
                     {(i == 0), 1'b1, (i == 0)});
         end
      end
   endtask

   task automatic test_row_end_and_hblank();
      clear_ram();
      ram[3] = 16'h8000;
      do_reset();
      for (int x = 0; x < HA; x++) begin
         if (x >= 48) begin
            total++;
            if (address !== 13'd3) begin
               bad++;
               $display("FAIL last_word_addr x=%0d got=%0d want=3", x, address);
            end
         end
         step();
         if (x >= 48) begin
            total++;
            if (pixel !== (x == 63)) begin
               bad++;
               $display("FAIL last_word_px x=%0d got=%b want=%b", x, pixel, (x == 63));
            end
         end
      end
      for (int x = HA; x < HT; x++) begin
         total++;
         if (address !== 13'd3) begin
            bad++;
            $display("FAIL hblank_addr_hold x=%0d got=%0d want=3", x, address);
         end
         step();
         total++;
         if ({hsync, pixel_valid, pixel} !== 3'b100) begin
            bad++;
            $display("FAIL hblank x=%0d got=%b want=100", x, {hsync, pixel_valid, pixel});
         end
      end
      total++;
      if (address !== 13'd4) begin
         bad++;
         $display("FAIL line1_addr got=%0d want=4", address);
      end
      step();
      total++;
      if ({hsync, pixel_valid} !== 2'b01) begin
         bad++;
         $display("FAIL line1_start got=%b want=01", {hsync, pixel_valid});
      end
   endtask

   task automatic test_full_frame();
      int tx, ty, vs_cnt, fs_prev, fs_period;
      logic [12:0] exp_addr, last_addr;
      logic [4:0]  exp_v, got_v;
      logic [15:0] img [0:15];
      logic        act;
      clear_ram();
      for (int i = 0; i < 16; i++) begin
         img[i] = 16'hA5C3 ^ (16'h1111 * 16'(i));
         ram[i] = img[i];
      end
      do_reset();
      tx = 0; ty = 0; vs_cnt = 0; fs_prev = -1; fs_period = 0; last_addr = '0;
      for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
         act      = (tx < HA) && (ty < VA);
         exp_addr = act ? 13'(ty * 4 + tx / 16) : last_addr;
         if (act) last_addr = exp_addr;
         total++;
         if (address !== exp_addr) begin
            bad++;
            $display("FAIL frame_addr x=%0d y=%0d got=%0d want=%0d", tx, ty, address, exp_addr);
         end
         // A write after the word's fetch must not reach this frame's pixels.
         if (cyc < FRAME && tx == 5 && ty == 0) ram[0] = 16'hFFFF;
         exp_v = {act ? img[ty * 4 + tx / 16][tx % 16] : 1'b0, act, (tx >= HA), (ty >= VA),
                  (tx == 0 && ty == 0)};
         step();
         got_v = {pixel, pixel_valid, hsync, vsync, frame_start};
         total++;
         if (got_v !== exp_v) begin
            bad++;
            $display("FAIL frame_outputs x=%0d y=%0d got=%b want=%b", tx, ty, got_v, exp_v);
         end
         if (vsync && cyc < FRAME) vs_cnt++;
         if (frame_start) begin
            if (fs_prev >= 0) fs_period = cyc - fs_prev;
            fs_prev = cyc;
         end
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
         if (cyc == FRAME - 1) begin
            total++;
            if (frame_count !== 16'd1) begin
               bad++;
               $display("FAIL frame_count_1 got=%0d want=1", frame_count);
            end
         end
`endif
         tx++;
         if (tx == HT) begin
            tx = 0;
            ty++;
            if (ty == VT) begin
               ty = 0;
               img[0] = 16'hFFFF;
            end
         end
      end
      total++;
      if (vs_cnt != VB * HT) begin
         bad++;
         $display("FAIL vsync_cycles got=%0d want=%0d", vs_cnt, VB * HT);
      end
      total++;
      if (fs_period != FRAME) begin
         bad++;
         $display("FAIL frame_period got=%0d want=%0d", fs_period, FRAME);
      end
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
      total++;
      if (frame_count !== 16'd2) begin
         bad++;
         $display("FAIL frame_count_2 got=%0d want=2", frame_count);
      end
`endif
   endtask

   task automatic test_stall();
      clear_ram();
      ram[0] = 16'hAAAA;
      do_reset();
      step();
      total++;
      if ({pixel, frame_start} !== 2'b01) begin
         bad++;
         $display("FAIL stall_px0 got=%b want=01", {pixel, frame_start});
      end
      enable = 1'b0;
      step();
      total++;
      if ({pixel, pixel_valid, frame_start} !== 3'b010) begin
         bad++;
         $display("FAIL stall_fs_drop got=%b want=010", {pixel, pixel_valid, frame_start});
      end
      enable = 1'b1;
      for (int i = 1; i < 3; i++) begin
         step();
         total++;
         if (pixel !== i[0]) begin
            bad++;
            $display("FAIL stall_pre px=%0d got=%b want=%b", i, pixel, i[0]);
         end
      end
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         total++;
         if ({pixel, pixel_valid, frame_start, address} !== {3'b010, 13'd0}) begin
            bad++;
            $display("FAIL stall_hold k=%0d got=%b/%0d want=010/0", k, {pixel, pixel_valid, frame_start}, address);
         end
      end
      enable = 1'b1;
      for (int i = 3; i < 16; i++) begin
         step();
         total++;
         if ({pixel, pixel_valid} !== {i[0], 1'b1}) begin
            bad++;
            $display("FAIL stall_resume px=%0d got=%b want=%b1", i, {pixel, pixel_valid}, i[0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_ram();
      ram[0]  = 16'h0003;
      ram[10] = 16'hFFFF;
      do_reset();
      for (int k = 0; k < 2 * HT + 40; k++) step();
      total++;
      if (address !== 13'd10) begin
         bad++;
         $display("FAIL mid_addr got=%0d want=10", address);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if ({pixel, pixel_valid, hsync, vsync, frame_start, address} !== {5'b0, 13'd0}) begin
         bad++;
         $display("FAIL mid_reset got=%b/%0d want=00000/0", {pixel, pixel_valid, hsync, vsync, frame_start}, address);
      end
`ifdef SCREEN_SCANNER_FRAME_COUNT_EN
      total++;
      if (frame_count !== 16'd0) begin
         bad++;
         $display("FAIL mid_reset_frame_count got=%0d want=0", frame_count);
      end
`endif
      step();
      total++;
      if ({pixel, pixel_valid, frame_start} !== 3'b111) begin
         bad++;
         $display("FAIL mid_restart got=%b want=111", {pixel, pixel_valid, frame_start});
      end
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_row_end_and_hblank();
      test_full_frame();
      test_stall();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
